// File: rtl/pc_seq_if.sv
// Fetch-side bundle for pc_seq: hazard/redirect/next-PC inputs and the PC outputs.
// master = fetch/hazard control driving the sequencer, slave = pc_seq itself.
interface pc_seq_if #(
  parameter int PC_WIDTH  = 48,
  parameter int RAS_DEPTH = 4
);
  localparam int CW = $clog2(RAS_DEPTH) + 1;

  logic                stall;
  logic                redirect_valid;
  logic [PC_WIDTH-1:0] redirect_pc;
  logic [PC_WIDTH-1:0] pred_pc;
  logic                call_fire;
  logic [PC_WIDTH-1:0] ret_addr;
  logic                ret_fire;
  logic [PC_WIDTH-1:0] pc;
  logic                pc_valid;
  logic                ret_wait;
  logic [CW-1:0]       ras_count;

  modport master (
    output stall, redirect_valid, redirect_pc, pred_pc, call_fire, ret_addr, ret_fire,
    input  pc, pc_valid, ret_wait, ras_count
  );

  modport slave (
    input  stall, redirect_valid, redirect_pc, pred_pc, call_fire, ret_addr, ret_fire,
    output pc, pc_valid, ret_wait, ras_count
  );
endinterface

// File: rtl/pc_seq.sv
// Y86 fetch PC sequencer: reset vector, stall, redirect, ret-wait FSM.
// Optional return-address stack compiled in with `define PCSEQ_RAS_EN.
module pc_seq #(
  parameter int          PC_WIDTH     = 48,
  parameter logic [47:0] RESET_VECTOR = 48'h0,
  parameter int          RAS_DEPTH    = 4
) (
  input  logic clk,
  input  logic rst,
  pc_seq_if.slave bus
);
  localparam int CW = $clog2(RAS_DEPTH) + 1;
  localparam logic [0:0] S_RUN     = 1'b0;
  localparam logic [0:0] S_RETWAIT = 1'b1;
  localparam logic [PC_WIDTH-1:0] RV = PC_WIDTH'(RESET_VECTOR);

  logic [0:0]          state;
  logic [PC_WIDTH-1:0] pc_q;
  logic                valid_q;
  logic                accept;
  logic                both;
  logic                ras_hit;
  logic [PC_WIDTH-1:0] ras_top;
  logic [CW-1:0]       cnt;

  // call/ret/pred only matter on an edge that is neither stalled, redirected nor waiting
  assign accept = !bus.stall && !bus.redirect_valid && (state == S_RUN);

`ifdef PCSEQ_RAS_EN
  localparam int PW = $clog2(RAS_DEPTH);

  logic [PC_WIDTH-1:0] ras_mem [RAS_DEPTH];
  logic [PW-1:0]       top;

  assign both    = bus.call_fire && bus.ret_fire;
  assign ras_hit = (cnt != '0);
  assign ras_top = ras_mem[top];

  // storage kept reset-free; entries are don't-care while cnt is zero
  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      if (both)
        ras_mem[top] <= bus.ret_addr;
      else if (bus.call_fire)
        ras_mem[top + PW'(1)] <= bus.ret_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      top <= '0;
      cnt <= '0;
    end else if (accept && !both) begin
      if (bus.call_fire) begin
        top <= top + PW'(1);
        if (cnt != CW'(RAS_DEPTH)) cnt <= cnt + CW'(1);
      end else if (bus.ret_fire && ras_hit) begin
        top <= top - PW'(1);
        cnt <= cnt - CW'(1);
      end
    end
  end
`else
  logic unused_ras;
  assign unused_ras = ^{bus.call_fire, bus.ret_addr};
  assign both    = 1'b0;
  assign ras_hit = 1'b0;
  assign ras_top = '0;
  assign cnt     = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RV;
      valid_q <= 1'b0;
      state   <= S_RUN;
    end else if (bus.redirect_valid) begin
      pc_q    <= bus.redirect_pc;
      valid_q <= 1'b0;
      state   <= S_RUN;
    end else if (bus.stall || state == S_RETWAIT) begin
      valid_q <= (state == S_RUN);
    end else if (bus.ret_fire && !both) begin
      if (ras_hit) begin
        pc_q    <= ras_top;
        valid_q <= 1'b1;
      end else begin
        state   <= S_RETWAIT;
        valid_q <= 1'b0;
      end
    end else begin
      pc_q    <= bus.pred_pc;
      valid_q <= 1'b1;
    end
  end

  assign bus.pc        = pc_q;
  assign bus.pc_valid  = valid_q;
  assign bus.ret_wait  = (state == S_RETWAIT);
  assign bus.ras_count = cnt;
endmodule

// File: tb/tb_pc_seq.sv
// Self-checking bench for pc_seq: directed scenarios plus random traffic
// compared against a queue-based return-stack model.
module tb_pc_seq;
  localparam int          PCW = 48;
  localparam int          DEP = 4;
  localparam int          CW  = $clog2(DEP) + 1;
  localparam logic [47:0] RV  = 48'h100;
`ifdef PCSEQ_RAS_EN
  localparam bit RAS_EN = 1'b1;
`else
  localparam bit RAS_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   nvec = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  pc_seq_if #(.PC_WIDTH(PCW), .RAS_DEPTH(DEP)) bus ();
  pc_seq #(.PC_WIDTH(PCW), .RESET_VECTOR(RV), .RAS_DEPTH(DEP)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  // reference model: what the fetch stage should see, from the rules alone
  logic [PCW-1:0] m_pc;
  bit             m_valid;
  bit             m_wait;
  logic [PCW-1:0] m_q[$];

  function automatic void model_edge();
    if (rst) begin
      m_pc = RV; m_valid = 0; m_wait = 0; m_q.delete();
    end else if (bus.redirect_valid) begin
      m_pc = bus.redirect_pc; m_valid = 0; m_wait = 0;
    end else if (bus.stall || m_wait) begin
      m_valid = !m_wait;
    end else if (RAS_EN && bus.call_fire && bus.ret_fire) begin
      if (m_q.size() > 0) m_q[m_q.size()-1] = bus.ret_addr;
      m_pc = bus.pred_pc; m_valid = 1;
    end else if (bus.ret_fire) begin
      if (m_q.size() > 0) begin
        m_pc = m_q.pop_back(); m_valid = 1;
      end else begin
        m_wait = 1; m_valid = 0;
      end
    end else begin
      if (bus.call_fire && RAS_EN) begin
        if (m_q.size() == DEP) void'(m_q.pop_front());
        m_q.push_back(bus.ret_addr);
      end
      m_pc = bus.pred_pc; m_valid = 1;
    end
  endfunction

  task automatic idle();
    rst = 0; bus.stall = 0; bus.redirect_valid = 0; bus.redirect_pc = '0;
    bus.pred_pc = '0; bus.call_fire = 0; bus.ret_addr = '0; bus.ret_fire = 0;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset(input int n);
    idle(); rst = 1;
    repeat (n) step();
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset(2);
    nvec++;
    if (bus.pc !== 48'h100 || bus.pc_valid !== 1'b0 || bus.ret_wait !== 1'b0 || bus.ras_count !== '0) begin
      nerr++; $display("FAIL reset: pc=%h v=%b w=%b n=%0d want pc=100 v=0 w=0 n=0", bus.pc, bus.pc_valid, bus.ret_wait, bus.ras_count);
    end
    bus.pred_pc = 48'h10A; step();
    nvec++;
    if (bus.pc !== 48'h10A || bus.pc_valid !== 1'b1) begin
      nerr++; $display("FAIL reset_release: pc=%h v=%b want pc=10a v=1", bus.pc, bus.pc_valid);
    end
  endtask

  task automatic test_stall_redirect();
    idle(); bus.stall = 1;
    for (int i = 0; i < 3; i++) begin
      bus.pred_pc = PCW'($urandom); bus.call_fire = 1'($urandom); bus.ret_fire = 1'($urandom);
      step();
      nvec++;
      if (bus.pc !== 48'h10A || bus.pc_valid !== 1'b1 || bus.ret_wait !== 1'b0) begin
        nerr++; $display("FAIL stall_hold[%0d]: pc=%h v=%b w=%b want pc=10a v=1 w=0", i, bus.pc, bus.pc_valid, bus.ret_wait);
      end
    end
    bus.call_fire = 0; bus.ret_fire = 0;
    bus.redirect_valid = 1; bus.redirect_pc = 48'h200; step();
    nvec++;
    if (bus.pc !== 48'h200 || bus.pc_valid !== 1'b0) begin
      nerr++; $display("FAIL stall_redirect: pc=%h v=%b want pc=200 v=0", bus.pc, bus.pc_valid);
    end
    idle(); bus.pred_pc = 48'h208; step();
    nvec++;
    if (bus.pc !== 48'h208 || bus.pc_valid !== 1'b1) begin
      nerr++; $display("FAIL post_redirect: pc=%h v=%b want pc=208 v=1", bus.pc, bus.pc_valid);
    end
  endtask

  task automatic test_call_ret();
    do_reset(1);
    bus.call_fire = 1; bus.ret_addr = 48'h31; bus.pred_pc = 48'h80; step();
    nvec++;
    if (bus.pc !== 48'h80 || bus.ras_count !== CW'(1) || bus.pc_valid !== 1'b1) begin
      nerr++; $display("FAIL call: pc=%h n=%0d v=%b want pc=80 n=1 v=1", bus.pc, bus.ras_count, bus.pc_valid);
    end
    idle(); bus.ret_fire = 1; bus.pred_pc = 48'h99; step();
    nvec++;
    if (bus.pc !== 48'h31 || bus.ras_count !== '0 || bus.pc_valid !== 1'b1 || bus.ret_wait !== 1'b0) begin
      nerr++; $display("FAIL ret_pred: pc=%h n=%0d v=%b w=%b want pc=31 n=0 v=1 w=0", bus.pc, bus.ras_count, bus.pc_valid, bus.ret_wait);
    end
  endtask

  task automatic test_ras_overflow();
    logic [PCW-1:0] want;
    do_reset(1);
    for (int i = 1; i <= 5; i++) begin
      bus.call_fire = 1; bus.ret_addr = PCW'(i * 16); bus.pred_pc = PCW'(32'h1000 + i); step();
    end
    nvec++;
    if (bus.ras_count !== CW'(DEP)) begin
      nerr++; $display("FAIL ras_full: n=%0d want n=%0d", bus.ras_count, DEP);
    end
    idle(); bus.ret_fire = 1;
    for (int i = 0; i < 4; i++) begin
      want = PCW'((5 - i) * 16);
      step();
      nvec++;
      if (bus.pc !== want || bus.pc_valid !== 1'b1 || bus.ret_wait !== 1'b0) begin
        nerr++; $display("FAIL ras_pop[%0d]: pc=%h v=%b w=%b want pc=%h v=1 w=0", i, bus.pc, bus.pc_valid, bus.ret_wait, want);
      end
    end
    step();
    nvec++;
    if (bus.pc !== 48'h20 || bus.ret_wait !== 1'b1 || bus.pc_valid !== 1'b0) begin
      nerr++; $display("FAIL ras_empty_pop: pc=%h w=%b v=%b want pc=20 w=1 v=0", bus.pc, bus.ret_wait, bus.pc_valid);
    end
    idle(); bus.redirect_valid = 1; bus.redirect_pc = 48'h10; step();
    nvec++;
    if (bus.pc !== 48'h10 || bus.ret_wait !== 1'b0 || bus.pc_valid !== 1'b0) begin
      nerr++; $display("FAIL ras_exit_wait: pc=%h w=%b v=%b want pc=10 w=0 v=0", bus.pc, bus.ret_wait, bus.pc_valid);
    end
  endtask

  task automatic test_ret_wait();
    logic [PCW-1:0] p0;
    do_reset(1);
    bus.pred_pc = 48'h3C; step();
    p0 = bus.pc;
    bus.ret_fire = 1; bus.pred_pc = 48'h77; step();
    for (int i = 0; i < 3; i++) begin
      nvec++;
      if (bus.pc !== p0 || bus.ret_wait !== 1'b1 || bus.pc_valid !== 1'b0) begin
        nerr++; $display("FAIL ret_wait_hold[%0d]: pc=%h w=%b v=%b want pc=%h w=1 v=0", i, bus.pc, bus.ret_wait, bus.pc_valid, p0);
      end
      bus.ret_fire = 1'($urandom); bus.call_fire = 1'($urandom); bus.pred_pc = PCW'($urandom);
      step();
    end
    idle(); bus.redirect_valid = 1; bus.redirect_pc = 48'h44; step();
    nvec++;
    if (bus.pc !== 48'h44 || bus.ret_wait !== 1'b0 || bus.pc_valid !== 1'b0) begin
      nerr++; $display("FAIL ret_wait_exit: pc=%h w=%b v=%b want pc=44 w=0 v=0", bus.pc, bus.ret_wait, bus.pc_valid);
    end
  endtask

  task automatic test_reset_in_retwait();
    do_reset(1);
    bus.call_fire = 1; bus.ret_fire = 1; bus.ret_addr = 48'h5; bus.pred_pc = 48'h60; step();
    idle(); bus.ret_fire = 1; step();
    nvec++;
    if (bus.ret_wait !== 1'b1) begin
      nerr++; $display("FAIL enter_wait: w=%b want w=1", bus.ret_wait);
    end
    idle(); rst = 1; step();
    nvec++;
    if (bus.pc !== 48'h100 || bus.ret_wait !== 1'b0 || bus.ras_count !== '0 || bus.pc_valid !== 1'b0) begin
      nerr++; $display("FAIL reset_in_wait: pc=%h w=%b n=%0d v=%b want pc=100 w=0 n=0 v=0", bus.pc, bus.ret_wait, bus.ras_count, bus.pc_valid);
    end
    rst = 0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      rst                = ($urandom_range(63) == 0);
      bus.redirect_valid = ($urandom_range(7) == 0);
      bus.stall          = ($urandom_range(5) == 0);
      bus.call_fire      = ($urandom_range(3) == 0);
      bus.ret_fire       = ($urandom_range(3) == 0);
      bus.redirect_pc    = PCW'({$urandom, $urandom});
      bus.pred_pc        = PCW'({$urandom, $urandom});
      bus.ret_addr       = PCW'({$urandom, $urandom});
      step();
      nvec++;
      if (bus.pc !== m_pc || bus.pc_valid !== m_valid || bus.ret_wait !== m_wait || bus.ras_count !== CW'(m_q.size())) begin
        nerr++;
        $display("FAIL random[%0d]: pc=%h v=%b w=%b n=%0d want pc=%h v=%b w=%b n=%0d", c,
                 bus.pc, bus.pc_valid, bus.ret_wait, bus.ras_count, m_pc, m_valid, m_wait, m_q.size());
      end
    end
  endtask

  initial begin
    idle(); rst = 1;
    test_reset();
    test_stall_redirect();
    if (RAS_EN) begin
      test_call_ret();
      test_ras_overflow();
    end
    test_ret_wait();
    test_reset_in_retwait();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/pc_seq.md
# pc_seq

Parametrised program-counter sequencer for the Y86 fetch stage. It replaces the bare PC register with a clocked PC that supports a reset vector, fetch stall, and back-end redirect with fixed priority. It also provides optional return-address prediction for `ret`. It sits between the fetch-stage next-PC logic and instruction memory, and is driven by hazard control and the execute/memory-stage redirect path.

## Interface
- `PC_WIDTH`, 48, width of every PC/address signal.
- `RESET_VECTOR`, 48'h0, PC value loaded on reset (truncated to `PC_WIDTH`).
- `RAS_DEPTH`, 4, return-address-stack entries; power of two, ≥2; used only when `PCSEQ_RAS_EN` is defined.
- `clk  in  1`  clock; all state updates on rising edge.
- `rst  in  1`  reset, synchronous, active-high.
- `stall  in  1`  hold PC (fetch/decode stall from hazard control).
- `redirect_valid  in  1`  back-end correction (mispredicted `jXX`, resolved `ret`).
- `redirect_pc  in  PC_WIDTH`  corrected PC.
- `pred_pc  in  PC_WIDTH`  fetch-predicted next PC (valC for taken/`call`, valP otherwise).
- `call_fire  in  1`  instruction at `pc` is `call`; push `ret_addr`.
- `ret_addr  in  PC_WIDTH`  valP of the `call`.
- `ret_fire  in  1`  instruction at `pc` is `ret`.
- `pc  out  PC_WIDTH`  current fetch address.
- `pc_valid  out  1`  `pc` is a fetch the pipeline must execute.
- `ret_wait  out  1`  PC held because a `ret` has no prediction.
- `ras_count  out  $clog2(RAS_DEPTH)+1`  live entries (0 when RAS compiled out).

## Operation
- Next-PC priority, highest first: `rst` → `RESET_VECTOR`; `redirect_valid` → `redirect_pc`; `stall` → hold; `ret_wait` state → hold; `ret_fire` → RAS top if available, else hold and enter `ret_wait`; otherwise → `pred_pc`.
- State machine, two states:
  - RUN: normal advance.
  - RETWAIT: entered when `ret_fire` is accepted (not stalled, not redirected) with no prediction. In RETWAIT, `pc` is frozen, `pc_valid`=0 and `ret_wait`=1. Exit to RUN only on `redirect_valid`.
  - `stall` does not change state.
- `call_fire`, `ret_fire` and `pred_pc` are ignored in a cycle where `stall`, `redirect_valid`, or the RETWAIT state is active.
- `pc_valid`:
  - 0 in the first cycle after reset.
  - 0 in the cycle after a redirect is taken, as a fetch bubble while the redirect target is fetched fresh.
  - 0 while in RETWAIT.
  - 1 otherwise.
- RAS (when compiled in): circular buffer with a top pointer.
  - Push on accepted `call_fire`. When full, the oldest entry is overwritten and `ras_count` stays at `RAS_DEPTH`.
  - Pop on accepted `ret_fire` with `ras_count`>0; the prediction is the current top.
  - `call_fire` and `ret_fire` both asserted: the stack is unchanged in count, the top is overwritten with `ret_addr`, and the next PC is `pred_pc`.
  - Redirect does not alter the RAS.
- All PC arithmetic is external; the block only selects and stores values. There is no wrap handling.

## Timing
- Reset values: `pc`=`RESET_VECTOR`, `pc_valid`=0, `ret_wait`=0, `ras_count`=0, state RUN. RAS entries are not cleared; they are don't-care while `ras_count`=0.
- Reset asserted mid-operation overrides everything on that edge, including pending RETWAIT.
- Latency: inputs sampled on edge N appear on `pc` after edge N; `pc` is a registered output with no combinational input→output path.
- `ret_wait` and `pc_valid` are registered and change on the same edge as `pc`.
- Redirect in the same cycle as `stall`: redirect wins, and the stall is discarded for that edge.

## Configuration
- `PCSEQ_RAS_EN` defined: RAS instantiated; `ret_fire` with `ras_count`>0 predicts from the stack without stalling.
- `PCSEQ_RAS_EN` undefined: no RAS storage; `ras_count` is tied to 0; every accepted `ret_fire` enters RETWAIT and waits for `redirect_valid`. This matches baseline Y86 `ret` handling.

## Test plan
- Reset: `rst`=1 for 2 cycles with `RESET_VECTOR`=48'h100 → `pc`=48'h100, `pc_valid`=0. The first edge after release with `pred_pc`=48'h10A gives `pc`=48'h10A and `pc_valid`=1.
- Stall vs. redirect: `stall`=1 for 3 cycles → `pc` held. In the same cycle as `stall`, assert `redirect_valid`=1 with `redirect_pc`=48'h200 → `pc`=48'h200 and `pc_valid`=0 for one cycle.
- Call/ret with RAS: `call_fire` with `ret_addr`=48'h31 and `pred_pc`=48'h80 → `pc`=48'h80, `ras_count`=1. Then `ret_fire` → `pc`=48'h31, `ras_count`=0, no bubble.
- RAS overflow (DEPTH 4): 5 pushes of 0x10…0x50, then 5 pops → predictions 0x50, 0x40, 0x30, 0x20. The fifth pop enters RETWAIT. `redirect_pc`=48'h10 exits RETWAIT.
- RAS compiled out: `ret_fire` → `ret_wait`=1 and `pc` frozen for 3 cycles with `stall`=0. Then `redirect_valid` with 48'h44 → `pc`=48'h44, `ret_wait`=0.
- Reset during RETWAIT → next `pc`=`RESET_VECTOR`, `ret_wait`=0, `ras_count`=0.
